// File: rtl/fpu_result_wb16.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_wb16
// Brief    : Retire/writeback stage behind the FP16 add/sub unit. Results are
//            buffered in a small FIFO with valid/ready on both sides. On
//            retire, the architectural condition-code register and a sticky
//            status-flag register are updated.
// Options  : FPU_FLAG_IRQ_EN - adds irq_mask input and a registered irq output
//            raised when any masked sticky flag is set.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_wb16 #(
  parameter int DEPTH = 2,
  parameter int FLAGW = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_result,
  input  logic [3:0]              in_cc,
  input  logic [FLAGW-1:0]        in_flags,
  input  logic                    flush,
  input  logic                    flag_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_result,
  output logic [3:0]              out_cc,
  output logic [3:0]              cc_reg,
  output logic [FLAGW-1:0]        sticky_flags,
`ifdef FPU_FLAG_IRQ_EN
  input  logic [FLAGW-1:0]        irq_mask,
  output logic                    irq,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [15:0]      res_q [DEPTH];
  logic [3:0]       cc_q  [DEPTH];
  logic [FLAGW-1:0] flg_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       cc_reg_q, cc_reg_d;
  logic [FLAGW-1:0] sticky_q, sticky_d;

  logic             push;
  logic             pop;

  // Head is read straight from registered storage, so there is no
  // combinational path from in_* to out_*.
  assign out_valid    = (count_q != '0);
  assign out_result   = res_q[rd_ptr_q];
  assign out_cc       = cc_q[rd_ptr_q];
  assign in_ready     = (count_q < C_DEPTH) || (out_valid && out_ready);
  assign count        = count_q;
  assign cc_reg       = cc_reg_q;
  assign sticky_flags = sticky_q;

  // A flush drops whatever transfer would otherwise happen this cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Architectural state updated on retire; clear-and-retire keeps only the
  // retiring op's flags.
  always_comb begin
    cc_reg_d = pop ? out_cc : cc_reg_q;
    sticky_d = (flag_clr ? '0 : sticky_q) | (pop ? flg_q[rd_ptr_q] : '0);
  end

  // FIFO payload storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i] <= '0;
        cc_q[i]  <= '0;
        flg_q[i] <= '0;
      end
    end else if (push) begin
      res_q[wr_ptr_q] <= in_result;
      cc_q[wr_ptr_q]  <= in_cc;
      flg_q[wr_ptr_q] <= in_flags;
    end
  end

  // Control and architectural state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cc_reg_q <= '0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cc_reg_q <= cc_reg_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef FPU_FLAG_IRQ_EN
  logic irq_q;

  // Interrupt tracks the next sticky value, so flag_clr/reset drop it too.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |(sticky_d & irq_mask);
  end

  assign irq = irq_q;
`endif

endmodule
`default_nettype wire
